mem_access_unit: RTL

//   Parametrised load/store unit that replaces the combinational data-memory path

---
 rtl/mem_access_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: valid/ready load/store unit with alignment, byte strobes, load extension and bus timeout
module mem_access_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic rdy_q, wr_q, fire, bad, tmo;
  logic [2:0] op_q;
  logic [OW-1:0] off, off_q;
  logic [7:0] cnt;
  logic [NB-1:0] mask;
  logic [6:0] lsh;
  logic [XLEN-1:0] lane, ld_data, rdata_nxt;
  logic signed [XLEN-1:0] ld_sx;
  logic [1:0] err_nxt;
  assign req_ready = rdy_q && state == IDLE;
  assign fire = req_valid && req_ready;
  assign off = req_addr[OW-1:0];
  assign tmo = cnt >= 8'(TIMEOUT_CYC - 1);
  always_comb begin
    bad = req_op == 3'b111 || (req_wr && req_op[2]) ||
          (XLEN == 32 && (req_op[1:0] == 2'd3 || req_op == 3'b110)) ||
          (req_op[1:0] == 2'd1 ? off[0] : req_op[1:0] == 2'd2 ? |off[1:0] : req_op[1:0] == 2'd3 ? |off : 1'b0);
    mask = req_op[1:0] == 2'd0 ? NB'(1) : req_op[1:0] == 2'd1 ? NB'(3) : req_op[1:0] == 2'd2 ? NB'(15) : '1;
    lane = bus_rdata >> {off_q, 3'b000};
    lsh = 7'(XLEN) - (7'd8 << op_q[1:0]);
    ld_sx = $signed(lane << lsh) >>> lsh;
    ld_data = op_q[2] ? (lane << lsh) >> lsh : ld_sx;
    state_nxt = state;
    err_nxt = 2'b00;
    rdata_nxt = '0;
    case (state)
      IDLE: begin
        state_nxt = fire ? (bad ? RESP : REQ) : IDLE;
        err_nxt = 2'b01;
      end
      REQ: begin
        state_nxt = bus_ready ? WAIT : tmo ? RESP : REQ;
        err_nxt = 2'b10;
      end
      WAIT: begin
        state_nxt = (bus_rvalid || tmo) ? RESP : WAIT;
        err_nxt = (bus_err || !bus_rvalid) ? 2'b10 : 2'b00;
        rdata_nxt = (bus_rvalid && !bus_err && !wr_q) ? ld_data : '0;
      end
      RESP: state_nxt = rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
      cnt <= '0;
      bus_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= '0;
      rsp_rdata <= '0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      op_q <= '0;
      wr_q <= 1'b0;
      off_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      cnt <= (state == REQ || state == WAIT) ? cnt + 8'd1 : 8'd0;
      bus_valid <= state_nxt == REQ;
      rsp_valid <= state_nxt == RESP;
      if (state != RESP && state_nxt == RESP) begin
        rsp_err <= err_nxt;
        rsp_rdata <= rdata_nxt;
      end
      if (fire) begin
        op_q <= req_op;
        wr_q <= req_wr;
        off_q <= off;
      end
      if (fire && !bad) begin
        bus_we <= req_wr;
        bus_addr <= {req_addr[ADDR_W-1:OW], OW'(0)};
        bus_wstrb <= req_wr ? mask << off : '0;
        bus_wdata <= req_wdata << {off, 3'b000};
      end
    end
  end
endmodule
